// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
//   state_t       : checker FSM states
//   ADDR_ID/TS    : word addresses inside the system-ID slave
//   SYSID_DATA_W  : slave data width
//   TIMER_W       : width of the shared stall/latency down-counter
package niosii_system_sysid_checker_pkg;

  localparam int SYSID_DATA_W = 32;
  localparam int TIMER_W      = 16;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WAIT_ID,
    S_RD_TS,
    S_WAIT_TS,
    S_COMPARE,
    S_DONE
  } state_t;

endpackage

// File: rtl/niosii_system_sysid_checker_read_timer.sv
// Down-counter shared between stall timeout and read-latency counting.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (has priority over i_en)
//   i_load_val     : value to load
//   i_en           : decrement by one (saturates at zero)
//   o_last         : counter holds 1, i.e. this enabled cycle is the final one
module niosii_system_sysid_checker_read_timer
  import niosii_system_sysid_checker_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_last
);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Not gated by i_en so the FSM can qualify it without a combinational loop.
  assign o_last = (r_cnt == TIMER_W'(1));

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID (word 0) and build
// timestamp (word 1) from the system-ID slave, compares both against the
// build constants and reports the result to boot/status logic.
//   clock, reset_n     : clock, asynchronous active-low reset
//   start              : request a check (sampled only in IDLE)
//   avm_address/read   : read master request
//   avm_waitrequest    : slave stall
//   avm_readdata       : slave read data
//   busy, done         : run in progress / one-cycle result-valid pulse
//   pass, id_match, ts_match, timeout_err : check results
//   id_value, ts_value : captured words
module niosii_system_sysid_checker
  import niosii_system_sysid_checker_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1488579697,
  parameter bit                      CHECK_TIMESTAMP    = 1'b1,
  parameter int                      READ_LATENCY       = 0,
  parameter int                      TIMEOUT_CYCLES     = 255,
  parameter bit                      AUTO_START         = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_match,
  output logic                    ts_match,
  output logic                    timeout_err,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] LAT_LOAD = TIMER_W'(READ_LATENCY);
  localparam bit                 HAS_LAT  = (READ_LATENCY != 0);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_auto;
  logic [SYSID_DATA_W-1:0] r_id_value;
  logic [SYSID_DATA_W-1:0] r_ts_value;
  logic                    r_id_match;
  logic                    r_ts_match;
  logic                    r_pass;
  logic                    r_timeout;

  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_en;
  logic               w_last;
  logic               w_read;
  logic               w_addr;
  logic               w_cap_id;
  logic               w_cap_ts;
  logic               w_timeout;
  logic               w_clear;
  logic               w_cmp;

  niosii_system_sysid_checker_read_timer u_timer (
    .i_clk      (clock),
    .i_rst_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_last     (w_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_auto  <= AUTO_START;
    end else begin
      r_state <= w_next;
      if (w_clear) r_auto <= 1'b0;
    end
  end

  // The timer is reloaded with the stall budget on entry to each RD state and
  // with the read latency on acceptance, so one counter serves both roles.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = TO_LOAD;
    w_en       = 1'b0;
    w_read     = 1'b0;
    w_addr     = ADDR_ID;
    w_cap_id   = 1'b0;
    w_cap_ts   = 1'b0;
    w_timeout  = 1'b0;
    w_clear    = 1'b0;
    w_cmp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || r_auto) begin
          w_next  = S_RD_ID;
          w_load  = 1'b1;
          w_clear = 1'b1;
        end
      end
      S_RD_ID: begin
        w_read = 1'b1;
        w_addr = ADDR_ID;
        if (!avm_waitrequest) begin
          w_load = 1'b1;
          if (HAS_LAT) begin
            w_next     = S_WAIT_ID;
            w_load_val = LAT_LOAD;
          end else begin
            w_cap_id = 1'b1;
            w_next   = S_RD_TS;
          end
        end else begin
          w_en = 1'b1;
          if (w_last) begin
            w_timeout = 1'b1;
            w_next    = S_DONE;
          end
        end
      end
      S_WAIT_ID: begin
        w_en = 1'b1;
        if (w_last) begin
          w_cap_id = 1'b1;
          w_load   = 1'b1;
          w_next   = S_RD_TS;
        end
      end
      S_RD_TS: begin
        w_read = 1'b1;
        w_addr = ADDR_TS;
        if (!avm_waitrequest) begin
          if (HAS_LAT) begin
            w_load     = 1'b1;
            w_load_val = LAT_LOAD;
            w_next     = S_WAIT_TS;
          end else begin
            w_cap_ts = 1'b1;
            w_next   = S_COMPARE;
          end
        end else begin
          w_en = 1'b1;
          if (w_last) begin
            w_timeout = 1'b1;
            w_next    = S_DONE;
          end
        end
      end
      S_WAIT_TS: begin
        w_en = 1'b1;
        if (w_last) begin
          w_cap_ts = 1'b1;
          w_next   = S_COMPARE;
        end
      end
      S_COMPARE: begin
        w_cmp  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Results persist until the next run leaves IDLE; a timeout leaves both
  // match bits and pass at their cleared value of 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_clear) begin
        r_id_value <= '0;
        r_ts_value <= '0;
        r_id_match <= 1'b0;
        r_ts_match <= 1'b0;
        r_pass     <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_cap_id)  r_id_value <= avm_readdata;
      if (w_cap_ts)  r_ts_value <= avm_readdata;
      if (w_timeout) r_timeout  <= 1'b1;
      if (w_cmp) begin
        r_id_match <= (r_id_value == EXPECTED_ID);
        r_ts_match <= (r_ts_value == EXPECTED_TIMESTAMP);
        r_pass     <= (r_id_value == EXPECTED_ID) &&
                      ((r_ts_value == EXPECTED_TIMESTAMP) || !CHECK_TIMESTAMP) &&
                      !r_timeout;
      end
    end
  end

  assign avm_read    = w_read;
  assign avm_address = w_addr;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign pass        = r_pass;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout_err = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for the system-ID checker. Instance A uses default parameters
// (zero latency, auto start); instance B uses READ_LATENCY=2,
// TIMEOUT_CYCLES=8, CHECK_TIMESTAMP=0, AUTO_START=0.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS_OK  = 32'd1488579697;
  localparam logic [31:0] TS_BAD = 32'd1488579696;
  localparam logic [31:0] JUNK   = 32'hDEADBEEF;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        idm;
    logic        tsm;
    logic        ps;
    logic        to;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   t0 = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic        a_start = 1'b0, a_wr = 1'b0;
  logic        a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
  logic [31:0] a_rdata, a_idv, a_tsv;
  logic [31:0] a_id_src = 32'd0, a_ts_src = TS_OK;
  assign a_rdata = a_addr ? a_ts_src : a_id_src;

  // Instance B signals
  logic        b_start = 1'b0, b_wr = 1'b0, b_early = 1'b0;
  logic        b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
  logic [31:0] b_rdata, b_idv, b_tsv;
  logic [31:0] b_id_src = 32'd0, b_ts_src = TS_OK;
  logic        b_v1, b_v2, b_a1, b_a2;

  // Latency-2 slave: data valid exactly two cycles after acceptance
  // (or one cycle after, in early mode), junk otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_v1 <= 1'b0; b_v2 <= 1'b0; b_a1 <= 1'b0; b_a2 <= 1'b0;
    end else begin
      b_v1 <= b_read & ~b_wr;
      b_a1 <= b_addr;
      b_v2 <= b_v1;
      b_a2 <= b_a1;
    end
  end
  assign b_rdata = b_early ? (b_v1 ? (b_a1 ? b_ts_src : b_id_src) : JUNK)
                           : (b_v2 ? (b_a2 ? b_ts_src : b_id_src) : JUNK);

  niosii_system_sysid_checker u_a (
    .clock(clk), .reset_n(rst_n), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wr),
    .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass),
    .id_match(a_idm), .ts_match(a_tsm), .timeout_err(a_to),
    .id_value(a_idv), .ts_value(a_tsv)
  );

  niosii_system_sysid_checker #(
    .CHECK_TIMESTAMP(1'b0), .READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
  ) u_b (
    .clock(clk), .reset_n(rst_n), .start(b_start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wr),
    .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
    .id_match(b_idm), .ts_match(b_tsm), .timeout_err(b_to),
    .id_value(b_idv), .ts_value(b_tsv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] id, input logic [31:0] ts, input logic idm,
                          input logic tsm, input logic ps, input logic to, input int lat);
    exp_t e;
    e.id = id; e.ts = ts; e.idm = idm; e.tsm = tsm; e.ps = ps; e.to = to; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns latency since t0, or -1 if done never came.
  task automatic wait_done(input bit inst_b, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      if ((inst_b ? b_done : a_done) === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_res(input string tag, input int lat, input logic [31:0] idv,
                           input logic [31:0] tsv, input logic idm, input logic tsm,
                           input logic ps, input logic to);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".lat"}, 32'(lat), 32'(e.lat));
    chk({tag, ".id_value"}, idv, e.id);
    chk({tag, ".ts_value"}, tsv, e.ts);
    chk({tag, ".id_match"}, 32'(idm), 32'(e.idm));
    chk({tag, ".ts_match"}, 32'(tsm), 32'(e.tsm));
    chk({tag, ".pass"}, 32'(ps), 32'(e.ps));
    chk({tag, ".timeout"}, 32'(to), 32'(e.to));
  endtask

  task automatic check_a(input string tag, input int lat);
    check_res(tag, lat, a_idv, a_tsv, a_idm, a_tsm, a_pass, a_to);
  endtask

  task automatic check_b(input string tag, input int lat);
    check_res(tag, lat, b_idv, b_tsv, b_idm, b_tsm, b_pass, b_to);
  endtask

  task automatic pulse_a();
    a_start = 1'b1; t0 = cyc;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic pulse_b();
    b_start = 1'b1; t0 = cyc;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.a_read", 32'(a_read), 32'd0);
    chk("rst.a_busy", 32'(a_busy), 32'd0);
    chk("rst.a_done", 32'(a_done), 32'd0);
    chk("rst.a_pass", 32'(a_pass), 32'd0);
    chk("rst.a_idv", a_idv, 32'd0);
    chk("rst.b_tsv", b_tsv, 32'd0);

    // Auto start after reset release
    rst_n = 1'b1; t0 = cyc;
    push_exp(32'd0, TS_OK, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    @(negedge clk);
    chk("auto.k1_read", 32'(a_read), 32'd1);
    chk("auto.k1_addr", 32'(a_addr), 32'd0);
    chk("auto.k1_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    chk("auto.k2_read", 32'(a_read), 32'd1);
    chk("auto.k2_addr", 32'(a_addr), 32'd1);
    wait_done(1'b0, 20, lat);
    check_a("auto", lat);
    @(negedge clk);
    chk("auto.done_single", 32'(a_done), 32'd0);
    chk("auto.busy_low", 32'(a_busy), 32'd0);
    chk("auto.b_idle", 32'(b_busy), 32'd0);

    // Timestamp mismatch with CHECK_TIMESTAMP=1
    a_ts_src = TS_BAD;
    push_exp(32'd0, TS_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    pulse_a();
    wait_done(1'b0, 20, lat);
    check_a("tsbad", lat);
    repeat (3) @(negedge clk);
    chk("tsbad.hold_tsv", a_tsv, TS_BAD);
    chk("tsbad.hold_idm", 32'(a_idm), 32'd1);
    a_ts_src = TS_OK;

    // Three stall cycles on each read
    push_exp(32'd0, TS_OK, 1'b1, 1'b1, 1'b1, 1'b0, 10);
    a_wr = 1'b1;
    pulse_a();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("stall.k%0d_read", k), 32'(a_read), 32'd1);
      chk($sformatf("stall.k%0d_addr", k), 32'(a_addr), (k <= 4) ? 32'd0 : 32'd1);
      a_wr = (k == 4 || k == 8) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    wait_done(1'b0, 20, lat);
    check_a("stall", lat);

    // start while busy, including during DONE, is dropped
    @(negedge clk);
    push_exp(32'd0, TS_OK, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    pulse_a();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    chk("busy_start.done_k4", 32'(a_done), 32'd1);
    check_a("busy_start", cyc - t0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("busy_start.k5_busy", 32'(a_busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_done === 1'b1 || a_busy === 1'b1) nd++;
    end
    chk("busy_start.no_rerun", 32'(nd), 32'd0);

    // Asynchronous reset during RD_TS, then auto rerun
    pulse_a();
    @(negedge clk);
    chk("rstmid.k2_read", 32'(a_read), 32'd1);
    chk("rstmid.k2_addr", 32'(a_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.read_async", 32'(a_read), 32'd0);
    chk("rstmid.busy_async", 32'(a_busy), 32'd0);
    chk("rstmid.addr_async", 32'(a_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid.read_held", 32'(a_read), 32'd0);
    rst_n = 1'b1; t0 = cyc;
    push_exp(32'd0, TS_OK, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    @(negedge clk);
    chk("rerun.k1_read", 32'(a_read), 32'd1);
    wait_done(1'b0, 20, lat);
    check_a("rerun", lat);
    @(negedge clk);

    // B: latency 2, timestamp mismatch ignored (CHECK_TIMESTAMP=0)
    b_ts_src = TS_BAD;
    push_exp(32'd0, TS_BAD, 1'b1, 1'b0, 1'b1, 1'b0, 8);
    pulse_b();
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("lat.k%0d_read", k), 32'(b_read), (k == 1 || k == 4) ? 32'd1 : 32'd0);
      if (k == 1 || k == 4)
        chk($sformatf("lat.k%0d_addr", k), 32'(b_addr), (k == 1) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    wait_done(1'b1, 20, lat);
    check_b("lat", lat);
    @(negedge clk);

    // B: data valid one cycle early must not be captured
    b_ts_src = TS_OK;
    b_early = 1'b1;
    push_exp(JUNK, JUNK, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    pulse_b();
    wait_done(1'b1, 20, lat);
    check_b("early", lat);
    @(negedge clk);
    b_early = 1'b0;

    // B: waitrequest stuck high -> timeout after 8 stall cycles
    push_exp(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    b_wr = 1'b1;
    pulse_b();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("tmo.k%0d_read", k), 32'(b_read), 32'd1);
    end
    @(negedge clk);
    chk("tmo.read_dropped", 32'(b_read), 32'd0);
    wait_done(1'b1, 20, lat);
    check_b("tmo", lat);
    @(negedge clk);
    chk("tmo.done_single", 32'(b_done), 32'd0);
    chk("tmo.busy_low", 32'(b_busy), 32'd0);
    chk("tmo.read_idle", 32'(b_read), 32'd0);
    b_wr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/niosii_system_sysid_checker.md
Name: niosII_system_sysid_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its output.
- On start, or automatically after reset, it reads word 0 (system ID) and word 1 (build timestamp), captures both and compares them with the expected build constants.
- It reports pass/fail, a timeout, and the captured values to the boot/status logic, so a mismatched bitstream/software pairing is flagged before the CPU runs.

Parameters:
- EXPECTED_ID, 0, system ID the software image was built against
- EXPECTED_TIMESTAMP, 1488579697, build timestamp the software image was built against
- CHECK_TIMESTAMP, 1, 1 = timestamp mismatch fails the check; 0 = timestamp is captured but ignored for pass
- READ_LATENCY, 0, fixed slave read latency in cycles after acceptance (0 = readdata valid in the accept cycle), range 0..3
- TIMEOUT_CYCLES, 255, maximum cycles a read may stall on waitrequest, range 1..65535
- AUTO_START, 1, 1 = one check is launched on the first clock after reset_n deasserts

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check; sampled only in IDLE
- avm_address  out  1  word address to the system-ID slave (0 = ID, 1 = timestamp)
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for the zero-wait system-ID slave
- avm_readdata  in  32  slave read data
- busy  out  1  high from leaving IDLE until DONE is exited
- done  out  1  one-cycle pulse when results are valid
- pass  out  1  id_match & (ts_match | ~CHECK_TIMESTAMP) & ~timeout_err
- id_match  out  1  captured ID equals EXPECTED_ID
- ts_match  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout_err  out  1  a read exceeded TIMEOUT_CYCLES
- id_value  out  32  captured system ID
- ts_value  out  32  captured timestamp

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0, avm_read drops immediately, FSM goes to IDLE, counters clear. Reset mid-read abandons the transaction with no further strobes.
- State sequence: IDLE -> RD_ID -> [WAIT_ID] -> RD_TS -> [WAIT_TS] -> COMPARE -> DONE -> IDLE. WAIT_* states are used only when READ_LATENCY>0.
- IDLE: on start=1 (or the first post-reset cycle when AUTO_START=1), go to RD_ID. On leaving IDLE, clear id_match, ts_match, pass, timeout_err, id_value and ts_value.
- RD_x: avm_read=1, avm_address = 0 (ID) or 1 (timestamp). Address and read are held stable while avm_waitrequest=1.
- A read is accepted in the cycle that avm_waitrequest=0.
  - READ_LATENCY=0: capture avm_readdata in the accept cycle and advance.
  - Otherwise: enter WAIT_x with avm_read=0, count READ_LATENCY cycles, and capture on the last of them.
- Timeout: a stall counter resets on entry to each RD_x and increments on every cycle with waitrequest=1. When it equals TIMEOUT_CYCLES, drop avm_read, set timeout_err=1, skip to DONE with pass=0 and both match bits 0.
- COMPARE: register id_match, ts_match and pass. The comparison is 32-bit equality; no partial compare.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Results are held stable until the next run starts.
- start while busy (including during DONE) is ignored and not queued.
- Zero-wait timing, READ_LATENCY=0, start high in cycle N:
  - N+1: read of address 0
  - N+2: read of address 1
  - N+3: COMPARE
  - N+4: done=1, results valid
  - N+5: busy=0
- Each cycle of READ_LATENCY adds one cycle per read; each stall cycle adds one.

Decomposition:
- Package niosII_system_sysid_pkg:
  - FSM state enum (IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE, DONE)
  - ADDR_ID=0, ADDR_TS=1
  - SYSID_DATA_W=32
- Sub-module niosII_system_sysid_read_timer: shared stall/latency down-counter with load, enable and expire outputs; instantiated once and reused for both timeout and latency counting.

Test Plan:
- Zero-wait slave returning ID 0 and timestamp 1488579697, start pulse -> reads at address 0 then 1 on consecutive cycles; done at start+4; pass=1, id_value=0, ts_value=1488579697.
- Slave returns timestamp 1488579696, CHECK_TIMESTAMP=1 -> ts_match=0, pass=0. Same stimulus with CHECK_TIMESTAMP=0 -> pass=1, ts_value=1488579696.
- waitrequest high for 3 cycles on each read, TIMEOUT_CYCLES=255 -> address and read stable while stalled; done at start+10; pass=1.
- waitrequest stuck high, TIMEOUT_CYCLES=8 -> avm_read drops after 8 stall cycles; timeout_err=1, pass=0, single done pulse, busy then 0.
- READ_LATENCY=2, data valid exactly 2 cycles after accept -> correct capture, avm_read low in WAIT states, done at start+8. Data changed 1 cycle early is not captured.
- AUTO_START=1: release reset -> check runs with no start pulse. Assert reset_n low during RD_TS -> avm_read and all outputs 0 asynchronously; re-released reset reruns the check. start during busy -> no second run.
